calc1_port_scheduler: RTL and testbench
=======================================

CALC1_PORT_SCHEDULER -- requirements
Module: calc1_port_scheduler

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, the maximum cycles to wait for alu_done before aborting an operation.
REQ-002 SHALL have port c_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have ports reqN_cmd_in, input, [0:3], N=1..4: port command; 0 is NOP, 1 is ADD, 2 is SUB, 5 is LSH, 6 is RSH.
REQ-005 SHALL have ports reqN_data_in, input, [0:31], N=1..4: operand 1 in the command cycle, operand 2 in the following cycle.
REQ-006 SHALL have ports out_dataN, output, [0:31], N=1..4: result data.
REQ-007 SHALL have ports out_respN, output, [0:1], N=1..4: response code; 0 none, 1 success, 2 invalid command or overflow, 3 internal error.
REQ-008 SHALL have port alu_req, output, 1 bit: operation request to the shared ALU.
REQ-009 SHALL have ports alu_cmd [0:3], alu_a [0:31] and alu_b [0:31], all outputs: the operation presented to the ALU.
REQ-010 SHALL have port alu_done, input, 1 bit: the ALU result is valid this cycle.
REQ-011 SHALL have ports alu_result [0:31] and alu_resp [0:1], both inputs: the ALU result data and its response code.

Function
REQ-012 SHALL keep one port FSM per port with states IDLE -> OPND2 -> PEND -> RESP -> IDLE.
REQ-013 In IDLE, when reqN_cmd_in != 0 the port SHALL capture the command and reqN_data_in (operand A), then go to OPND2.
REQ-014 In OPND2 the port SHALL capture reqN_data_in as operand B unconditionally and go to PEND; reqN_cmd_in is ignored in this cycle.
REQ-015 While a port is in OPND2, PEND or RESP, it SHALL ignore reqN_cmd_in, including a command presented in the RESP cycle.
REQ-016 A captured command outside {1,2,5,6} SHALL never be issued to the ALU; the port SHALL go to RESP with out_resp=2 and out_data=0 on the cycle after OPND2.
REQ-017 SHALL allow only one ALU operation outstanding, using a controller FSM with states IDLE -> ISSUE -> IDLE.
REQ-018 Controller IDLE SHALL grant the first port in PEND with a valid command, searching round-robin from pointer rr; it SHALL then set rr to granted+1 (mod 4) and go to ISSUE.
REQ-019 SHALL reset rr to port 1.
REQ-020 In ISSUE, alu_req SHALL be 1, with alu_cmd, alu_a and alu_b holding the granted port's buffers and stable until exit.
REQ-021 alu_req SHALL be 0, and alu_cmd, alu_a and alu_b SHALL be 0, outside ISSUE.
REQ-022 alu_done SHALL be sampled only in ISSUE, and is ignored elsewhere.
REQ-023 On alu_done=1 in ISSUE, the scheduler SHALL capture alu_result and alu_resp into the granted port, move that port to RESP, and return the controller to IDLE in the same edge.
REQ-024 SHALL count ISSUE cycles; if the count reaches TIMEOUT without alu_done, the granted port SHALL go to RESP with resp=3 and data=0, and the controller SHALL return to IDLE.
REQ-025 The timeout counter SHALL be cleared on entry to ISSUE.
REQ-026 In RESP, out_dataN and out_respN SHALL show the result for exactly one cycle; they SHALL be 0 in every other state.
REQ-027 The controller MAY grant a new port in the cycle it returns to IDLE; back-to-back grants SHALL be separated by at least one IDLE cycle.
REQ-028 Minimum latency: cmd at edge t, operand B at t+1, alu_req at t+2, alu_done at t+2 gives out_resp at t+3.
REQ-029 The scheduler SHALL not modify data: widths pass through, and no arithmetic is performed in the scheduler.
REQ-030 Ports SHALL be independent; commands on all four ports in the same cycle SHALL all be accepted.

Reset
REQ-031 reset=0 SHALL asynchronously force all port FSMs and the controller to IDLE, rr to 1, the counter to 0, and all outputs and buffers to 0.
REQ-032 A reset mid-operation SHALL discard all pending and outstanding work, with no response produced.
REQ-033 After reset is released, the first command SHALL be accepted on the first rising edge with reset=1.

Verification
REQ-034 Port1 ADD with A=0x5 then B=0x7, ALU returning result 0xC, resp 1, done after 1 cycle -> out_data1=0xC and out_resp1=1 for exactly one cycle, then 0.
REQ-035 All four ports issue ADD in the same cycle -> grants in order 1,2,3,4; a second round started with rr=3 -> order 3,4,1,2.
REQ-036 Port2 cmd=4 with operands 0x1, 0x2 -> alu_req never asserted; out_resp2=2 and out_data2=0 at the cycle after operand B.
REQ-037 alu_done held at 0 -> after 15 ISSUE cycles out_resp=3 on the granted port; the next pending port is then granted normally.
REQ-038 reset=0 asserted while in ISSUE -> alu_req=0 immediately with no response on any port; a new command after reset completes correctly.
REQ-039 Port3 presents a cmd during its RESP cycle -> the command is ignored; a command presented on the next cycle is accepted.

Source files
------------

// File: rtl/calc1_port_scheduler.sv
// Four-port command front end sharing a single ALU.
// Each port collects a two-operand command; a round-robin controller issues one op at a time.
module calc1_port_scheduler #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic [3:0]  req1_cmd_in,
    input  logic [3:0]  req2_cmd_in,
    input  logic [3:0]  req3_cmd_in,
    input  logic [3:0]  req4_cmd_in,
    input  logic [31:0] req1_data_in,
    input  logic [31:0] req2_data_in,
    input  logic [31:0] req3_data_in,
    input  logic [31:0] req4_data_in,
    output logic [31:0] out_data1,
    output logic [31:0] out_data2,
    output logic [31:0] out_data3,
    output logic [31:0] out_data4,
    output logic [1:0]  out_resp1,
    output logic [1:0]  out_resp2,
    output logic [1:0]  out_resp3,
    output logic [1:0]  out_resp4,
    output logic        alu_req,
    output logic [3:0]  alu_cmd,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic        alu_done,
    input  logic [31:0] alu_result,
    input  logic [1:0]  alu_resp
);

    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {PIdle, POpnd2, PPend, PResp} port_state_e;
    typedef enum logic {CIdle, CIssue} ctrl_state_e;

    logic [3:0]  cmd_in  [4];
    logic [31:0] data_in [4];

    port_state_e pst_q   [4];
    port_state_e pst_d   [4];
    logic [3:0]  cmd_q   [4];
    logic [3:0]  cmd_d   [4];
    logic [31:0] a_q     [4];
    logic [31:0] a_d     [4];
    logic [31:0] b_q     [4];
    logic [31:0] b_d     [4];
    logic [31:0] rdata_q [4];
    logic [31:0] rdata_d [4];
    logic [1:0]  rresp_q [4];
    logic [1:0]  rresp_d [4];

    ctrl_state_e   cst_q, cst_d;
    logic [1:0]    rr_q, rr_d;
    logic [1:0]    gnt_q, gnt_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          issue_done, issue_abort, found;

    assign cmd_in[0]  = req1_cmd_in;
    assign cmd_in[1]  = req2_cmd_in;
    assign cmd_in[2]  = req3_cmd_in;
    assign cmd_in[3]  = req4_cmd_in;
    assign data_in[0] = req1_data_in;
    assign data_in[1] = req2_data_in;
    assign data_in[2] = req3_data_in;
    assign data_in[3] = req4_data_in;

    function automatic logic cmd_valid(input logic [3:0] c);
        return (c == 4'd1) || (c == 4'd2) || (c == 4'd5) || (c == 4'd6);
    endfunction

    // Controller: round-robin grant from rr, then hold the op until done or timeout.
    always_comb begin
        cst_d       = cst_q;
        rr_d        = rr_q;
        gnt_d       = gnt_q;
        tmr_d       = tmr_q;
        issue_done  = 1'b0;
        issue_abort = 1'b0;
        found       = 1'b0;
        case (cst_q)
            CIdle: begin
                for (int k = 0; k < 4; k++) begin
                    logic [1:0] idx;
                    idx = rr_q + 2'(k);
                    if (!found && pst_q[idx] == PPend && cmd_valid(cmd_q[idx])) begin
                        found = 1'b1;
                        gnt_d = idx;
                    end
                end
                if (found) begin
                    rr_d  = gnt_d + 2'd1;
                    tmr_d = '0;
                    cst_d = CIssue;
                end
            end
            CIssue: begin
                if (alu_done) begin
                    issue_done = 1'b1;
                    cst_d      = CIdle;
                end else if (tmr_q == TW'(TIMEOUT - 1)) begin
                    issue_abort = 1'b1;
                    cst_d       = CIdle;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: cst_d = CIdle;
        endcase
    end

    // Per-port FSMs; commands are only looked at in PIdle.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            pst_d[i]   = pst_q[i];
            cmd_d[i]   = cmd_q[i];
            a_d[i]     = a_q[i];
            b_d[i]     = b_q[i];
            rdata_d[i] = rdata_q[i];
            rresp_d[i] = rresp_q[i];
            case (pst_q[i])
                PIdle: begin
                    if (cmd_in[i] != 4'd0) begin
                        cmd_d[i] = cmd_in[i];
                        a_d[i]   = data_in[i];
                        pst_d[i] = POpnd2;
                    end
                end
                POpnd2: begin
                    b_d[i] = data_in[i];
                    if (cmd_valid(cmd_q[i])) begin
                        pst_d[i] = PPend;
                    end else begin
                        rdata_d[i] = '0;
                        rresp_d[i] = 2'd2;
                        pst_d[i]   = PResp;
                    end
                end
                PPend: begin
                    if (cst_q == CIssue && gnt_q == 2'(i)) begin
                        if (issue_done) begin
                            rdata_d[i] = alu_result;
                            rresp_d[i] = alu_resp;
                            pst_d[i]   = PResp;
                        end else if (issue_abort) begin
                            rdata_d[i] = '0;
                            rresp_d[i] = 2'd3;
                            pst_d[i]   = PResp;
                        end
                    end
                end
                PResp:   pst_d[i] = PIdle;
                default: pst_d[i] = PIdle;
            endcase
        end
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            cst_q <= CIdle;
            rr_q  <= 2'd0;
            gnt_q <= 2'd0;
            tmr_q <= '0;
            for (int i = 0; i < 4; i++) begin
                pst_q[i]   <= PIdle;
                cmd_q[i]   <= '0;
                a_q[i]     <= '0;
                b_q[i]     <= '0;
                rdata_q[i] <= '0;
                rresp_q[i] <= '0;
            end
        end else begin
            cst_q <= cst_d;
            rr_q  <= rr_d;
            gnt_q <= gnt_d;
            tmr_q <= tmr_d;
            for (int i = 0; i < 4; i++) begin
                pst_q[i]   <= pst_d[i];
                cmd_q[i]   <= cmd_d[i];
                a_q[i]     <= a_d[i];
                b_q[i]     <= b_d[i];
                rdata_q[i] <= rdata_d[i];
                rresp_q[i] <= rresp_d[i];
            end
        end
    end

    assign out_data1 = (pst_q[0] == PResp) ? rdata_q[0] : '0;
    assign out_data2 = (pst_q[1] == PResp) ? rdata_q[1] : '0;
    assign out_data3 = (pst_q[2] == PResp) ? rdata_q[2] : '0;
    assign out_data4 = (pst_q[3] == PResp) ? rdata_q[3] : '0;
    assign out_resp1 = (pst_q[0] == PResp) ? rresp_q[0] : '0;
    assign out_resp2 = (pst_q[1] == PResp) ? rresp_q[1] : '0;
    assign out_resp3 = (pst_q[2] == PResp) ? rresp_q[2] : '0;
    assign out_resp4 = (pst_q[3] == PResp) ? rresp_q[3] : '0;

    assign alu_req = (cst_q == CIssue);
    assign alu_cmd = alu_req ? cmd_q[gnt_q] : '0;
    assign alu_a   = alu_req ? a_q[gnt_q]   : '0;
    assign alu_b   = alu_req ? b_q[gnt_q]   : '0;

endmodule

// File: tb/tb_calc1_port_scheduler.sv
// Directed bench for calc1_port_scheduler: table of single-port ops plus multi-cycle sequences.
module tb_calc1_port_scheduler;

    logic        c_clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  cmd_in   [4];
    logic [31:0] data_in  [4];
    logic [31:0] out_data [4];
    logic [1:0]  out_resp [4];
    logic        alu_req;
    logic [3:0]  alu_cmd;
    logic [31:0] alu_a, alu_b;
    logic        alu_done;
    logic [31:0] alu_result;
    logic [1:0]  alu_resp;

    int errors = 0;
    int checks = 0;

    always #5 c_clk = ~c_clk;

    calc1_port_scheduler #(.TIMEOUT(15)) dut (
        .c_clk        (c_clk),
        .reset        (reset),
        .req1_cmd_in  (cmd_in[0]),
        .req2_cmd_in  (cmd_in[1]),
        .req3_cmd_in  (cmd_in[2]),
        .req4_cmd_in  (cmd_in[3]),
        .req1_data_in (data_in[0]),
        .req2_data_in (data_in[1]),
        .req3_data_in (data_in[2]),
        .req4_data_in (data_in[3]),
        .out_data1    (out_data[0]),
        .out_data2    (out_data[1]),
        .out_data3    (out_data[2]),
        .out_data4    (out_data[3]),
        .out_resp1    (out_resp[0]),
        .out_resp2    (out_resp[1]),
        .out_resp3    (out_resp[2]),
        .out_resp4    (out_resp[3]),
        .alu_req      (alu_req),
        .alu_cmd      (alu_cmd),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_done     (alu_done),
        .alu_result   (alu_result),
        .alu_resp     (alu_resp)
    );

    typedef struct {
        int          port;
        logic [3:0]  cmd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [1:0]  resp;
        int          done_after;   // ISSUE cycle on which the ALU answers; 0 = never
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        int          exp_issues;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " alu_req"}, 32'(alu_req), 32'd0);
        check({tag, " alu_a"}, alu_a, 32'd0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s resp%0d", tag, i + 1), 32'(out_resp[i]), 32'd0);
            check($sformatf("%s data%0d", tag, i + 1), out_data[i], 32'd0);
        end
    endtask

    task automatic run_op(input vec_t v, input string tag);
        int p;
        int issues;
        int at;
        bit got;
        p = v.port; issues = 0; at = -1; got = 1'b0;
        @(negedge c_clk); cmd_in[p] = v.cmd; data_in[p] = v.a;
        @(negedge c_clk); cmd_in[p] = 4'd0; data_in[p] = v.b;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge c_clk);
            alu_done = 1'b0; data_in[p] = '0;
            if (out_resp[p] != 2'd0) begin
                got = 1'b1; at = k;
                check({tag, " data"}, out_data[p], v.exp_data);
                check({tag, " resp"}, 32'(out_resp[p]), 32'(v.exp_resp));
                check({tag, " req_low_at_resp"}, 32'(alu_req), 32'd0);
            end else if (alu_req) begin
                issues++;
                if (issues == 1) begin
                    check({tag, " alu_cmd"}, 32'(alu_cmd), 32'(v.cmd));
                    check({tag, " alu_a"}, alu_a, v.a);
                    check({tag, " alu_b"}, alu_b, v.b);
                end
                if (issues == v.done_after) begin
                    alu_done = 1'b1; alu_result = v.res; alu_resp = v.resp;
                end
            end
        end
        check({tag, " responded"}, 32'(got), 32'd1);
        check({tag, " issue_cycles"}, 32'(issues), 32'(v.exp_issues));
        check({tag, " latency"}, 32'(at), 32'((v.exp_issues == 0) ? 0 : v.exp_issues + 1));
        @(negedge c_clk);
        check({tag, " resp_one_cycle"}, 32'(out_resp[p]), 32'd0);
        check({tag, " data_one_cycle"}, out_data[p], 32'd0);
    endtask

    task automatic run_all4(input int e0, input int e1, input int e2, input int e3,
                            input string tag);
        int order[4];
        int exp_order[4];
        int ng;
        int nresp;
        exp_order[0] = e0; exp_order[1] = e1; exp_order[2] = e2; exp_order[3] = e3;
        ng = 0; nresp = 0;
        @(negedge c_clk);
        for (int i = 0; i < 4; i++) begin cmd_in[i] = 4'd1; data_in[i] = 32'h100 + 32'(i); end
        @(negedge c_clk);
        for (int i = 0; i < 4; i++) begin cmd_in[i] = 4'd0; data_in[i] = 32'h200 + 32'(i); end
        for (int k = 0; k < 60 && nresp < 4; k++) begin
            @(negedge c_clk);
            alu_done = 1'b0;
            for (int i = 0; i < 4; i++) data_in[i] = '0;
            for (int i = 0; i < 4; i++) begin
                if (out_resp[i] != 2'd0) begin
                    nresp++;
                    check($sformatf("%s resp%0d", tag, i + 1), 32'(out_resp[i]), 32'd1);
                    check($sformatf("%s data%0d", tag, i + 1), out_data[i],
                          32'h300 + 32'(2 * i));
                end
            end
            if (alu_req) begin
                if (ng < 4) order[ng] = int'(alu_a) - 32'sh100;
                ng++;
                alu_done = 1'b1; alu_result = alu_a + alu_b; alu_resp = 2'd1;
            end
        end
        check({tag, " responses"}, 32'(nresp), 32'd4);
        check({tag, " grants"}, 32'(ng), 32'd4);
        for (int g = 0; g < 4 && g < ng; g++)
            check($sformatf("%s grant%0d", tag, g), 32'(order[g]), 32'(exp_order[g]));
    endtask

    initial begin
        bit got0, got1, seen;
        int cnt0, cnt1;

        vecs[0] = '{0, 4'd1, 32'h5,        32'h7,  32'hC,        2'd1, 1, 32'hC,        2'd1, 1};
        vecs[1] = '{1, 4'd2, 32'h10,       32'h3,  32'hD,        2'd1, 3, 32'hD,        2'd1, 3};
        vecs[2] = '{2, 4'd5, 32'h1,        32'h4,  32'h10,       2'd1, 2, 32'h10,       2'd1, 2};
        vecs[3] = '{3, 4'd6, 32'h80000000, 32'd31, 32'h1,        2'd1, 1, 32'h1,        2'd1, 1};
        vecs[4] = '{1, 4'd4, 32'h1,        32'h2,  32'h0,        2'd0, 0, 32'h0,        2'd2, 0};
        vecs[5] = '{0, 4'd1, 32'hFFFFFFFF, 32'h2,  32'h1234,     2'd2, 1, 32'h1234,     2'd2, 1};
        vecs[6] = '{2, 4'hF, 32'h9,        32'h9,  32'h0,        2'd0, 0, 32'h0,        2'd2, 0};
        vecs[7] = '{3, 4'd1, 32'h3,        32'h4,  32'h7,        2'd1, 0, 32'h0,        2'd3, 15};

        for (int i = 0; i < 4; i++) begin cmd_in[i] = '0; data_in[i] = '0; end
        alu_done = 1'b0; alu_result = '0; alu_resp = '0;

        #1;
        check_quiet("reset");
        @(negedge c_clk); @(negedge c_clk);
        reset = 1'b1;

        // rr starts at port 1; a lone port-2 op then moves it to port 3.
        run_all4(0, 1, 2, 3, "all4_rr1");
        run_op(vecs[1], "rr_step_port2");
        run_all4(2, 3, 0, 1, "all4_rr3");

        for (int v = 0; v < 8; v++) run_op(vecs[v], $sformatf("vec%0d", v));

        // Ports 1 and 2 pending together; port 1 times out, then port 2 is served.
        @(negedge c_clk);
        cmd_in[0] = 4'd1; data_in[0] = 32'hA0; cmd_in[1] = 4'd2; data_in[1] = 32'hB0;
        @(negedge c_clk);
        cmd_in[0] = 4'd0; data_in[0] = 32'hA1; cmd_in[1] = 4'd0; data_in[1] = 32'hB1;
        got0 = 1'b0; got1 = 1'b0; cnt0 = 0; cnt1 = 0;
        for (int k = 0; k < 60 && !got1; k++) begin
            @(negedge c_clk);
            alu_done = 1'b0; data_in[0] = '0; data_in[1] = '0;
            if (out_resp[0] != 2'd0) begin
                got0 = 1'b1;
                check("tmo resp1", 32'(out_resp[0]), 32'd3);
                check("tmo data1", out_data[0], 32'd0);
            end
            if (out_resp[1] != 2'd0) begin
                got1 = 1'b1;
                check("tmo next resp2", 32'(out_resp[1]), 32'd1);
                check("tmo next data2", out_data[1], 32'h55);
            end
            if (alu_req && alu_a == 32'hA0) cnt0++;
            if (alu_req && alu_a == 32'hB0) begin
                cnt1++;
                check("tmo next alu_cmd", 32'(alu_cmd), 32'd2);
                alu_done = 1'b1; alu_result = 32'h55; alu_resp = 2'd1;
            end
        end
        check("tmo got1", 32'(got0), 32'd1);
        check("tmo got2", 32'(got1), 32'd1);
        check("tmo issue_cycles", 32'(cnt0), 32'd15);
        check("tmo next issues", 32'(cnt1), 32'd1);

        // Port 3: command during RESP is dropped, the one on the following cycle is taken.
        @(negedge c_clk); cmd_in[2] = 4'd1; data_in[2] = 32'h10;
        @(negedge c_clk); cmd_in[2] = 4'd0; data_in[2] = 32'h20;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge c_clk);
            alu_done = 1'b0; data_in[2] = '0;
            if (out_resp[2] != 2'd0) seen = 1'b1;
            else if (alu_req) begin alu_done = 1'b1; alu_result = 32'h30; alu_resp = 2'd1; end
        end
        check("respcmd first resp", 32'(out_resp[2]), 32'd1);
        cmd_in[2] = 4'd2; data_in[2] = 32'hDEAD;
        @(negedge c_clk);
        check("respcmd idle after", 32'(out_resp[2]), 32'd0);
        cmd_in[2] = 4'd5; data_in[2] = 32'h22;
        @(negedge c_clk);
        cmd_in[2] = 4'd0; data_in[2] = 32'h3;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge c_clk);
            alu_done = 1'b0; data_in[2] = '0;
            if (alu_req) begin
                seen = 1'b1;
                check("respcmd alu_cmd", 32'(alu_cmd), 32'd5);
                check("respcmd alu_a", alu_a, 32'h22);
                check("respcmd alu_b", alu_b, 32'h3);
                alu_done = 1'b1; alu_result = 32'h88; alu_resp = 2'd1;
            end
        end
        check("respcmd issued", 32'(seen), 32'd1);
        @(negedge c_clk);
        alu_done = 1'b0;
        check("respcmd resp", 32'(out_resp[2]), 32'd1);
        check("respcmd data", out_data[2], 32'h88);

        // Reset while an op is outstanding.
        @(negedge c_clk); cmd_in[0] = 4'd1; data_in[0] = 32'h1;
        @(negedge c_clk); cmd_in[0] = 4'd0; data_in[0] = 32'h2;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge c_clk);
            data_in[0] = '0;
            if (alu_req) seen = 1'b1;
        end
        check("rst issue reached", 32'(seen), 32'd1);
        reset = 1'b0;
        #1;
        check_quiet("rst async");
        @(negedge c_clk);
        check_quiet("rst held");
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge c_clk);
            check_quiet($sformatf("rst after%0d", k));
        end
        run_op(vecs[0], "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1);
    end

endmodule
